// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational ALU, with a registered response slot per requester.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default build is round-robin.
module alu_share_arbiter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5,
    parameter int FNW  = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid_0,
    output logic            req_ready_0,
    input  logic [XLEN-1:0] req_a_0,
    input  logic [XLEN-1:0] req_b_0,
    input  logic [SHW-1:0]  req_shamt_0,
    input  logic [FNW-1:0]  req_alufn_0,
    output logic            rsp_valid_0,
    input  logic            rsp_ready_0,
    output logic [XLEN-1:0] rsp_r_0,
    output logic [3:0]      rsp_flags_0,

    input  logic            req_valid_1,
    output logic            req_ready_1,
    input  logic [XLEN-1:0] req_a_1,
    input  logic [XLEN-1:0] req_b_1,
    input  logic [SHW-1:0]  req_shamt_1,
    input  logic [FNW-1:0]  req_alufn_1,
    output logic            rsp_valid_1,
    input  logic            rsp_ready_1,
    output logic [XLEN-1:0] rsp_r_1,
    output logic [3:0]      rsp_flags_1,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [SHW-1:0]  alu_shamt,
    output logic [FNW-1:0]  alu_alufn,
    input  logic [XLEN-1:0] alu_r,
    input  logic            alu_cf,
    input  logic            alu_zf,
    input  logic            alu_vf,
    input  logic            alu_sf
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

    slot_t           r_slot_0;
    slot_t           r_slot_1;
    slot_t           w_slot_nxt_0;
    slot_t           w_slot_nxt_1;

    logic [XLEN-1:0] r_rsp_r_0;
    logic [XLEN-1:0] r_rsp_r_1;
    logic [3:0]      r_rsp_flags_0;
    logic [3:0]      r_rsp_flags_1;

    logic            w_elig_0;
    logic            w_elig_1;
    logic            w_grant_0;
    logic            w_grant_1;
    logic [3:0]      w_alu_flags;

`ifndef ALU_SHARE_FIXED_PRIO_EN
    logic            r_last_grant;
`endif

    // A full slot that is being drained this cycle can accept a new result.
    assign w_elig_0 = ~rst & req_valid_0 & ((r_slot_0 == SLOT_EMPTY) | rsp_ready_0);
    assign w_elig_1 = ~rst & req_valid_1 & ((r_slot_1 == SLOT_EMPTY) | rsp_ready_1);

`ifdef ALU_SHARE_FIXED_PRIO_EN
    assign w_grant_0 = w_elig_0;
    assign w_grant_1 = w_elig_1 & ~w_elig_0;
`else
    assign w_grant_1 = w_elig_1 & (~w_elig_0 | ~r_last_grant);
    assign w_grant_0 = w_elig_0 & ~w_grant_1;
`endif

    assign req_ready_0 = w_grant_0;
    assign req_ready_1 = w_grant_1;
    assign w_alu_flags = {alu_cf, alu_zf, alu_vf, alu_sf};

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_shamt = '0;
        alu_alufn = '0;
        if (w_grant_0) begin
            alu_a     = req_a_0;
            alu_b     = req_b_0;
            alu_shamt = req_shamt_0;
            alu_alufn = req_alufn_0;
        end else if (w_grant_1) begin
            alu_a     = req_a_1;
            alu_b     = req_b_1;
            alu_shamt = req_shamt_1;
            alu_alufn = req_alufn_1;
        end
    end

    always_comb begin
        w_slot_nxt_0 = r_slot_0;
        w_slot_nxt_1 = r_slot_1;
        if (w_grant_0)
            w_slot_nxt_0 = SLOT_FULL;
        else if ((r_slot_0 == SLOT_FULL) && rsp_ready_0)
            w_slot_nxt_0 = SLOT_EMPTY;
        if (w_grant_1)
            w_slot_nxt_1 = SLOT_FULL;
        else if ((r_slot_1 == SLOT_FULL) && rsp_ready_1)
            w_slot_nxt_1 = SLOT_EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_0 <= SLOT_EMPTY;
            r_slot_1 <= SLOT_EMPTY;
        end else begin
            r_slot_0 <= w_slot_nxt_0;
            r_slot_1 <= w_slot_nxt_1;
        end
    end

`ifndef ALU_SHARE_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_grant <= 1'b1;
        else if (w_grant_0)
            r_last_grant <= 1'b0;
        else if (w_grant_1)
            r_last_grant <= 1'b1;
    end
`endif

    // Response payload only loads on a grant, so an unconsumed result is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_r_0     <= '0;
            r_rsp_flags_0 <= '0;
            r_rsp_r_1     <= '0;
            r_rsp_flags_1 <= '0;
        end else begin
            if (w_grant_0) begin
                r_rsp_r_0     <= alu_r;
                r_rsp_flags_0 <= w_alu_flags;
            end
            if (w_grant_1) begin
                r_rsp_r_1     <= alu_r;
                r_rsp_flags_1 <= w_alu_flags;
            end
        end
    end

    assign rsp_valid_0 = (r_slot_0 == SLOT_FULL);
    assign rsp_valid_1 = (r_slot_1 == SLOT_FULL);
    assign rsp_r_0     = r_rsp_r_0;
    assign rsp_r_1     = r_rsp_r_1;
    assign rsp_flags_0 = r_rsp_flags_0;
    assign rsp_flags_1 = r_rsp_flags_1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed stimulus pushes hand-computed results,
// a negedge monitor pops them as responses are consumed.
module tb_alu_share_arbiter;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0;
    logic [31:0] req_a_0, req_b_0, rsp_r_0;
    logic [4:0]  req_shamt_0;
    logic [3:0]  req_alufn_0, rsp_flags_0;
    logic        req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1;
    logic [31:0] req_a_1, req_b_1, rsp_r_1;
    logic [4:0]  req_shamt_1;
    logic [3:0]  req_alufn_1, rsp_flags_1;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_alufn;
    logic        alu_cf, alu_zf, alu_vf, alu_sf;

    int total = 0;
    int bad   = 0;
    logic [35:0] q0[$];
    logic [35:0] q1[$];

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
        .req_shamt_0(req_shamt_0), .req_alufn_0(req_alufn_0), .rsp_valid_0(rsp_valid_0),
        .rsp_ready_0(rsp_ready_0), .rsp_r_0(rsp_r_0), .rsp_flags_0(rsp_flags_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
        .req_shamt_1(req_shamt_1), .req_alufn_1(req_alufn_1), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_1(rsp_ready_1), .rsp_r_1(rsp_r_1), .rsp_flags_1(rsp_flags_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_alufn(alu_alufn),
        .alu_r(alu_r), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_vf(alu_vf), .alu_sf(alu_sf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared combinational ALU model driven by the arbiter's alu_* outputs.
    always_comb begin
        logic [32:0] w_sum;
        w_sum  = '0;
        alu_r  = '0;
        alu_cf = 1'b0;
        alu_vf = 1'b0;
        case (alu_alufn)
            4'd0: begin
                w_sum  = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r  = w_sum[31:0];
                alu_cf = w_sum[32];
                alu_vf = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'd1: begin
                w_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_r  = w_sum[31:0];
                alu_cf = w_sum[32];
                alu_vf = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'd2:  alu_r = alu_b;
            4'd3:  alu_r = alu_a | alu_b;
            4'd4:  alu_r = alu_a & alu_b;
            4'd5:  alu_r = alu_a ^ alu_b;
            4'd6:  alu_r = alu_a >> alu_shamt;
            4'd7:  alu_r = alu_a << alu_shamt;
            4'd8:  alu_r = $unsigned($signed(alu_a) >>> alu_shamt);
            4'd9:  alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd10: alu_r = {31'd0, alu_a < alu_b};
            default: alu_r = '0;
        endcase
        alu_zf = (alu_r == 32'd0);
        alu_sf = alu_r[31];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid_0 && rsp_ready_0) begin
            if (q0.size() == 0) chk("rsp0_unexpected", 64'd1, 64'd0);
            else chk("rsp0_data", {28'd0, rsp_r_0, rsp_flags_0}, {28'd0, q0.pop_front()});
        end
        if (!rst && rsp_valid_1 && rsp_ready_1) begin
            if (q1.size() == 0) chk("rsp1_unexpected", 64'd1, 64'd0);
            else chk("rsp1_data", {28'd0, rsp_r_1, rsp_flags_1}, {28'd0, q1.pop_front()});
        end
    end

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] fn);
        req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_shamt_0 = sh; req_alufn_0 = fn;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] fn);
        req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_shamt_1 = sh; req_alufn_1 = fn;
    endtask

    // One cycle: check grants at negedge, record expected results of accepted ops, advance.
    task automatic step(input string nm, input logic g0, input logic g1,
                        input logic [35:0] e0, input logic [35:0] e1);
        @(negedge clk);
        chk({nm, "_ready0"}, {63'd0, req_ready_0}, {63'd0, g0});
        chk({nm, "_ready1"}, {63'd0, req_ready_1}, {63'd0, g1});
        if (req_valid_0 && req_ready_0) q0.push_back(e0);
        if (req_valid_1 && req_ready_1) q1.push_back(e1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        logic g;
        logic [31:0] neg;
        rst = 1'b1;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        set0(1'b1, 32'd5, 32'd3, 5'd0, 4'd1);
        set1(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready0", {63'd0, req_ready_0}, 64'd0);
        chk("reset_valid0", {63'd0, rsp_valid_0}, 64'd0);
        chk("reset_valid1", {63'd0, rsp_valid_1}, 64'd0);
        chk("reset_r0", {32'd0, rsp_r_0}, 64'd0);
        chk("reset_flags1", {60'd0, rsp_flags_1}, 64'd0);
        chk("reset_alu_a", {32'd0, alu_a}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single op: 5 - 3 = 2, carry (no borrow) set.
        step("single", 1'b1, 1'b0, {32'd2, 4'b1000}, 36'd0);
        set0(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        @(negedge clk);
        chk("single_latency", {63'd0, rsp_valid_0}, 64'd1);
        @(posedge clk); #1;

        // Idle: shared ALU inputs zero, nothing granted or filled.
        repeat (3) begin
            @(negedge clk);
            chk("idle_alu", {alu_a, alu_b}, 64'd0);
            chk("idle_ctl", {55'd0, alu_shamt, alu_alufn}, 64'd0);
            chk("idle_state", {60'd0, req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1}, 64'd0);
            @(posedge clk); #1;
        end
        // Last grant was 0 and idle left it alone, so round-robin now favours 1.
        set0(1'b1, 32'd2, 32'd3, 5'd0, 4'd4);
        set1(1'b1, 32'd1, 32'd0, 5'd4, 4'd7);
        step("idle_contend", FIXED, !FIXED, {32'd2, 4'b0000}, {32'd16, 4'b0000});
        set0(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        set1(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        @(posedge clk); #1;

        // Backpressure on slot 0 while requester 1 keeps flowing.
        rsp_ready_0 = 1'b0;
        set0(1'b1, 32'd7, 32'd7, 5'd0, 4'd5);
        step("bp_fill", 1'b1, 1'b0, {32'd0, 4'b0100}, 36'd0);
        set0(1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd0);
        for (int k = 1; k <= 10; k++) begin
            set1(1'b1, 32'd0, k, 5'd0, 4'd2);
            step("bp", 1'b0, 1'b1, 36'd0, {k[31:0], 4'b0000});
            chk("bp_hold", {27'd0, rsp_valid_0, rsp_r_0, rsp_flags_0}, {27'd0, 1'b1, 32'd0, 4'b0100});
        end
        set1(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);

        // Drain and refill in the same cycle: FFFFFFFF + 1 = 0 with carry and zero.
        rsp_ready_0 = 1'b1;
        step("refill", 1'b1, 1'b0, {32'd0, 4'b1100}, 36'd0);
        set0(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        @(negedge clk);
        chk("refill_valid", {63'd0, rsp_valid_0}, 64'd1);
        @(posedge clk); #1;

        // Async reset with slot 1 full and an op in flight on port 0.
        rsp_ready_1 = 1'b0;
        set1(1'b1, 32'd0, 32'd9, 5'd0, 4'd2);
        step("pre_rst", 1'b0, 1'b1, 36'd0, {32'd9, 4'b0000});
        set1(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        set0(1'b1, 32'd1, 32'd1, 5'd0, 4'd0);
        @(negedge clk);
        chk("inflight_ready0", {63'd0, req_ready_0}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", {62'd0, rsp_valid_0, rsp_valid_1}, 64'd0);
        chk("arst_r1", {32'd0, rsp_r_1}, 64'd0);
        chk("arst_ready0", {63'd0, req_ready_0}, 64'd0);
        q0.delete();
        q1.delete();
        set0(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready_1 = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {62'd0, rsp_valid_0, rsp_valid_1}, 64'd0);
        @(posedge clk); #1;

        // Contention with both slots always drained: 0,1,0,1 (or 0,0,0,0 with fixed priority).
        n0 = 0; n1 = 0;
        for (int j = 0; j < 8; j++) begin
            set0(1'b1, 32'd10 + n0, 32'd1, 5'd0, 4'd0);
            set1(1'b1, 32'd0, 32'd1 + n1, 5'd0, 4'd1);
            g = FIXED ? 1'b1 : ((j % 2) == 0);
            neg = 32'd0 - (32'd1 + n1);
            step("contend", g, !g, {32'd11 + n0, 4'b0000}, {neg, 4'b0001});
            if (g) n0++; else n1++;
        end
        set0(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        set1(1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 64'd0);
        chk("q1_drained", q1.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
